// File: rtl/traffic_led_drv_pkg.sv
// Purpose: shared light-code constants, driver state encoding and code legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

  // Light codes, shared with the upstream traffic-light controller.
  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_RED    = 3'b001;
  localparam logic [2:0] LED_GREEN  = 3'b010;
  localparam logic [2:0] LED_YELLOW = 3'b100;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    PEND   = 2'd1,
    FAULT  = 2'd2
  } drv_state_t;

  // A code is legal when at most one light is lit.
  function automatic logic is_legal(input logic [2:0] code);
    return (code == LED_OFF) || (code == LED_RED) ||
           (code == LED_GREEN) || (code == LED_YELLOW);
  endfunction

endpackage

// File: rtl/traffic_led_drv_if.sv
// Purpose: bundle between light controller (master) and LED driver (slave).
// Latency: n/a (wiring only).
// Backpressure: none; the driver accepts a code every cycle.
// Signals: led_code/duty towards the driver; led_out/fault/phase_sec back.
interface traffic_led_drv_if #(
  parameter int PWM_BITS = 8
);
  logic [2:0]          led_code;
  logic [PWM_BITS-1:0] duty;
  logic [2:0]          led_out;
  logic                fault;
  logic [3:0]          phase_sec;

  modport master (
    output led_code, duty,
    input  led_out, fault, phase_sec
  );

  modport slave (
    input  led_code, duty,
    output led_out, fault, phase_sec
  );
endinterface

// File: rtl/traffic_led_drv_tick_gen.sv
// Purpose: free-running prescaler producing half-second and one-second strobes.
// Latency: strobes are decoded from the counter register, one cycle wide.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), half_tick, sec_tick.
// TICK_1S must be even and >= 4 so both half-periods are equal and non-empty.
module tick_gen #(
  parameter int TICK_1S = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic half_tick,
  output logic sec_tick
);
  localparam int CW = $clog2(TICK_1S);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICK_1S / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(TICK_1S - 1);

  logic [CW-1:0] pre_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == FULL_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CW'(1);
    end
  end

  assign sec_tick  = (pre_cnt == FULL_LAST);
  assign half_tick = sec_tick || (pre_cnt == HALF_LAST);

endmodule

// File: rtl/traffic_led_drv.sv
// Purpose: drive LED pins from controller light code with PWM, yellow blink, phase timer and sticky fault.
// Latency: led_code -> led_out is 2 cycles (input register, then output register).
// Backpressure: none; a new code is accepted every cycle.
// Ports: clk, rst (sync, active-high), drv (slave side: led_code, duty in; led_out, fault, phase_sec out).
module traffic_led_drv
  import traffic_pkg::*;
#(
  parameter int TICK_1S      = 50_000_000,
  parameter int PWM_BITS     = 8,
  parameter int FAULT_SEC    = 3,
  parameter int YELLOW_BLINK = 1
) (
  input  logic               clk,
  input  logic               rst,
  traffic_led_drv_if.slave   drv
);

  logic [2:0]          code_q;
  logic [2:0]          code_prev;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink;
  logic                half_tick;
  logic                sec_tick;
  drv_state_t          state;
  logic [3:0]          pend_cnt;
  logic [2:0]          led_out_q;
  logic                fault_q;
  logic [3:0]          phase_q;

  logic                pwm_on;
  logic                code_legal;
  logic [2:0]          blink_mask;
  logic [2:0]          normal_led;
  logic [3:0]          phase_next;

  tick_gen #(
    .TICK_1S (TICK_1S)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .half_tick (half_tick),
    .sec_tick  (sec_tick)
  );

  // Input pipeline, PWM counter and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= LED_OFF;
      code_prev <= LED_OFF;
      pwm_cnt   <= '0;
      blink     <= 1'b0;
    end else begin
      code_q    <= drv.led_code;
      code_prev <= code_q;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      if (half_tick) begin
        blink <= ~blink;
      end
    end
  end

  // All-ones duty is forced fully on; otherwise the compare would leave
  // one dark cycle per PWM period.
  assign pwm_on     = (pwm_cnt < drv.duty) || (&drv.duty);
  assign code_legal = is_legal(code_q);
  assign blink_mask = (YELLOW_BLINK != 0) ? {blink, 2'b11} : 3'b111;
  assign normal_led = code_q & {3{pwm_on}} & blink_mask;

  // A code change clears the timer even if a second boundary lands on the
  // same cycle; otherwise count seconds and stick at 15.
  always_comb begin
    phase_next = phase_q;
    if (code_q != code_prev) begin
      phase_next = 4'd0;
    end else if (sec_tick && (phase_q != 4'hF)) begin
      phase_next = phase_q + 4'd1;
    end
  end

  // Outputs are computed from the state held before each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORMAL;
      pend_cnt  <= 4'd0;
      led_out_q <= LED_OFF;
      fault_q   <= 1'b0;
      phase_q   <= 4'd0;
    end else begin
      case (state)
        NORMAL: begin
          phase_q <= phase_next;
          if (code_legal) begin
            led_out_q <= normal_led;
          end else begin
            state     <= PEND;
            pend_cnt  <= 4'd0;
            led_out_q <= LED_OFF;
          end
        end
        PEND: begin
          led_out_q <= LED_OFF;
          phase_q   <= phase_next;
          // A legal code beats a timeout on the same cycle. The prescaler
          // is free-running, so the first counted second may be partial.
          if (code_legal) begin
            state <= NORMAL;
          end else if (sec_tick) begin
            if (pend_cnt == 4'(FAULT_SEC - 1)) begin
              state <= FAULT;
            end else begin
              pend_cnt <= pend_cnt + 4'd1;
            end
          end
        end
        FAULT: begin
          // Sticky: only rst leaves this state. Red flashes at full brightness.
          fault_q   <= 1'b1;
          led_out_q <= {2'b00, blink};
          phase_q   <= 4'd0;
        end
        default: begin
          state <= NORMAL;
        end
      endcase
    end
  end

  assign drv.led_out   = led_out_q;
  assign drv.fault     = fault_q;
  assign drv.phase_sec = phase_q;

endmodule

// File: tb/tb_traffic_led_drv.sv
// Purpose: randomized plus directed stimulus for traffic_led_drv against a timeline-based reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: none.
module tb_traffic_led_drv;
  import traffic_pkg::*;

  localparam int T  = 10;
  localparam int PB = 4;
  localparam int FS = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_led_drv_if #(.PWM_BITS(PB)) bus_b ();
  traffic_led_drv_if #(.PWM_BITS(PB)) bus_s ();

  traffic_led_drv #(
    .TICK_1S(T), .PWM_BITS(PB), .FAULT_SEC(FS), .YELLOW_BLINK(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .drv (bus_b)
  );

  traffic_led_drv #(
    .TICK_1S(T), .PWM_BITS(PB), .FAULT_SEC(FS), .YELLOW_BLINK(0)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .drv (bus_s)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: time is the count of edges since reset, so the
  // prescaler, blink and PWM positions follow by plain arithmetic.
  int         e;
  logic [2:0] cur_code;     // code the driver is acting on
  logic [2:0] last_code;    // code it acted on one cycle earlier
  bit         faulted;
  int         run_secs;     // whole seconds counted in the current illegal run
  logic [2:0] x_led_b, x_led_s;
  logic       x_fault;
  logic [3:0] x_phase;

  function automatic bit legal(input logic [2:0] c);
    return $countones(c) <= 1;
  endfunction

  task automatic model_edge(input logic [2:0] code, input logic [3:0] d, input logic r);
    bit sec, blk, on;
    int pwm;
    if (r) begin
      e = 0; cur_code = 3'b000; last_code = 3'b000;
      faulted = 0; run_secs = 0;
      x_led_b = 3'b000; x_led_s = 3'b000; x_fault = 1'b0; x_phase = 4'd0;
      return;
    end
    e++;
    sec = ((e - 1) % T) == T - 1;
    blk = (((e - 1) / (T / 2)) % 2) == 1;
    pwm = (e - 1) % (1 << PB);
    on  = (pwm < int'(d)) || (int'(d) == (1 << PB) - 1);
    if (faulted) begin
      x_fault = 1'b1;
      x_led_b = {2'b00, blk};
      x_led_s = {2'b00, blk};
      x_phase = 4'd0;
    end else begin
      x_fault = 1'b0;
      // Dark while the code is illegal and for the one cycle after it clears.
      if (!legal(cur_code) || !legal(last_code)) begin
        x_led_b = 3'b000;
        x_led_s = 3'b000;
      end else begin
        x_led_s = on ? cur_code : 3'b000;
        x_led_b = blk ? x_led_s : (x_led_s & 3'b011);
      end
      if (cur_code != last_code) x_phase = 4'd0;
      else if (sec && x_phase < 4'd15) x_phase = x_phase + 4'd1;
      if (legal(cur_code) || legal(last_code)) begin
        run_secs = 0;
      end else if (sec) begin
        run_secs++;
        if (run_secs == FS) faulted = 1;
      end
    end
    last_code = cur_code;
    cur_code  = code;
  endtask

  task automatic step(input logic [2:0] code, input logic [3:0] d, input logic r);
    bus_b.led_code = code; bus_s.led_code = code;
    bus_b.duty     = d;    bus_s.duty     = d;
    rst            = r;
    @(posedge clk);
    model_edge(code, d, r);
    #1;
    chk("led_out_blink",  32'(bus_b.led_out),   32'(x_led_b));
    chk("led_out_steady", 32'(bus_s.led_out),   32'(x_led_s));
    chk("fault",          32'(bus_b.fault),     32'(x_fault));
    chk("fault_steady",   32'(bus_s.fault),     32'(x_fault));
    chk("phase_sec",      32'(bus_b.phase_sec), 32'(x_phase));
    chk("phase_steady",   32'(bus_s.phase_sec), 32'(x_phase));
  endtask

  task automatic seg(input logic [2:0] code, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(code, d, 1'b0);
  endtask

  initial begin
    bus_b.led_code = 3'b000; bus_s.led_code = 3'b000;
    bus_b.duty = 4'h0; bus_s.duty = 4'h0;
    rst = 1'b1;
    #1;
    step(3'b000, 4'h0, 1'b1);
    step(3'b000, 4'h0, 1'b1);

    // Directed sequence following the bring-up plan.
    seg(LED_RED, 4'hF, 40);
    seg(LED_GREEN, 4'h4, 48);
    seg(LED_GREEN, 4'h0, 20);
    seg(LED_YELLOW, 4'hF, 30);
    seg(3'b011, 4'hF, 15);
    seg(LED_RED, 4'hF, 30);
    seg(3'b110, 4'h9, 40);
    seg(LED_GREEN, 4'hF, 20);
    step(LED_GREEN, 4'hF, 1'b1);
    seg(LED_RED, 4'hF, 210);
    // Line up so the code change reaches the driver on a second boundary.
    for (int i = 0; i < T && ((e + 2) % T) != 0; i++) step(LED_RED, 4'hF, 1'b0);
    seg(LED_GREEN, 4'hF, 12);

    // Randomized segments: mostly legal codes, some illegal, occasional reset.
    for (int s = 0; s < 60; s++) begin
      logic [2:0] c;
      logic [3:0] d;
      int         n;
      logic [2:0] legal_tab [4];
      legal_tab = '{LED_OFF, LED_RED, LED_GREEN, LED_YELLOW};
      if ($urandom_range(0, 9) < 7) c = legal_tab[$urandom_range(0, 3)];
      else c = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 45);
      if ($urandom_range(0, 19) == 0) step(c, d, 1'b1);
      seg(c, d, n);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
